// File: rtl/fetch_queue_if.sv
// Fetch-queue handshake bundle: IF push side, ID pop side, occupancy.
interface fetch_queue_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                  if_valid_i;
  logic [DATA_WIDTH-1:0] if_pc_i;
  logic [DATA_WIDTH-1:0] if_instr_i;
  logic                  if_ready_o;
  logic                  id_valid_o;
  logic [DATA_WIDTH-1:0] id_pc_o;
  logic [DATA_WIDTH-1:0] id_instr_o;
  logic                  id_ready_i;
  logic [CNT_W-1:0]      count_o;

  // Master: the IF/ID pipeline side driving pushes and pops.
  modport master (
    output if_valid_i, if_pc_i, if_instr_i, id_ready_i,
    input  if_ready_o, id_valid_o, id_pc_o, id_instr_o, count_o
  );

  // Slave: the queue itself.
  modport slave (
    input  if_valid_i, if_pc_i, if_instr_i, id_ready_i,
    output if_ready_o, id_valid_o, id_pc_o, id_instr_o, count_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular FIFO of PC/instruction pairs between IF and ID.
module fetch_queue #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  fetch_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic not_full;
  logic not_empty;
  logic push;
  logic pop;

  // Handshake qualifiers come only from registered occupancy (plus rst on the IF side).
  always_comb begin
    not_full  = (count != CNT_W'(DEPTH));
    not_empty = (count != CNT_W'(0));
    push      = bus.if_valid_i && !rst && not_full && !flush_i;
    pop       = not_empty && bus.id_ready_i && !flush_i;
  end

  // Outputs: ready/valid, occupancy and the head entry through a DEPTH:1 mux.
  always_comb begin
    bus.if_ready_o = !rst && not_full;
    bus.id_valid_o = not_empty;
    bus.count_o    = count;
    bus.id_pc_o    = '0;
    bus.id_instr_o = NOP_INSTR;
    if (not_empty) begin
      bus.id_pc_o    = pc_mem[rd_ptr];
      bus.id_instr_o = instr_mem[rd_ptr];
    end
  end

  // Entry storage; contents survive flush and reset, only the pointers matter.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= bus.if_pc_i;
      instr_mem[wr_ptr] <= bus.if_instr_i;
    end
  end

  // Pointer and occupancy update; flush and reset both return to empty.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Occupancy must never exceed the storage size.
  assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed test-plan scenarios plus random traffic against a queue model.
module tb_fetch_queue;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  fetch_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t model_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   seen_40     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every cycle: compare DUT outputs against the queue model, then advance the model.
  always @(negedge clk) begin : cmp
    int          n;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    ent_t        e;
    n       = model_q.size();
    e_ready = !rst && (n != DEPTH);
    e_valid = (n != 0);
    e_pc    = e_valid ? model_q[0].pc : 32'h0;
    e_instr = e_valid ? model_q[0].instr : NOP;
    chk("if_ready", 32'(bus.if_ready_o), 32'(e_ready));
    chk("id_valid", 32'(bus.id_valid_o), 32'(e_valid));
    chk("id_pc",    bus.id_pc_o, e_pc);
    chk("id_instr", bus.id_instr_o, e_instr);
    chk("count",    32'(bus.count_o), 32'(n));
    if (bus.id_valid_o && bus.id_pc_o == 32'h40) seen_40 = 1'b1;
    if (rst || flush) begin
      model_q.delete();
    end else begin
      if (e_valid && bus.id_ready_i) void'(model_q.pop_front());
      if (e_ready && bus.if_valid_i) begin
        e.pc    = bus.if_pc_i;
        e.instr = bus.if_instr_i;
        model_q.push_back(e);
      end
    end
  end

  // Apply one cycle of inputs just after the rising edge; returns with outputs settled.
  task automatic drive(input logic r, input logic f, input logic v,
                       input logic [31:0] pc, input logic rdy);
    @(posedge clk);
    #1;
    rst            = r;
    flush          = f;
    bus.if_valid_i = v;
    bus.if_pc_i    = pc;
    bus.if_instr_i = $urandom;
    bus.id_ready_i = rdy;
    #1;
  endtask

  initial begin : stim
    logic [31:0] pc_next;
    int          bias;
    rst            = 1'b1;
    flush          = 1'b0;
    bus.if_valid_i = 1'b1;
    bus.if_pc_i    = 32'h100;
    bus.if_instr_i = 32'hdead_beef;
    bus.id_ready_i = 1'b0;

    // Reset held two cycles with IF requesting.
    drive(1, 0, 1, 32'h100, 0);
    drive(1, 0, 1, 32'h100, 0);
    chk("rst_if_ready", 32'(bus.if_ready_o), 32'd0);
    chk("rst_id_valid", 32'(bus.id_valid_o), 32'd0);
    chk("rst_id_instr", bus.id_instr_o, 32'h13);
    chk("rst_id_pc",    bus.id_pc_o, 32'h0);
    chk("rst_count",    32'(bus.count_o), 32'd0);
    drive(0, 0, 0, 32'h0, 0);
    chk("post_rst_ready", 32'(bus.if_ready_o), 32'd1);

    // Fill to full with ID stalled.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 32'(4 * i), 0);
      chk("fill_count", 32'(bus.count_o), 32'(i));
    end
    drive(0, 0, 1, 32'h10, 0);
    chk("full_count", 32'(bus.count_o), 32'd4);
    chk("full_ready", 32'(bus.if_ready_o), 32'd0);
    chk("full_head",  bus.id_pc_o, 32'h0);
    drive(0, 0, 1, 32'h10, 0);
    chk("full_no_push", 32'(bus.count_o), 32'd4);
    chk("full_head2",   bus.id_pc_o, 32'h0);

    // Drain from full while refilling: strict order, pointers wrap.
    pc_next = 32'h10;
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 1, pc_next, 1);
      chk("drain_valid", 32'(bus.id_valid_o), 32'd1);
      chk("drain_head",  bus.id_pc_o, 32'(4 * k));
      if (bus.if_ready_o) pc_next = pc_next + 32'd4;
    end

    // Simultaneous push/pop at occupancy 2.
    drive(0, 1, 0, 32'h0, 0);
    drive(0, 0, 1, 32'h200, 0);
    drive(0, 0, 1, 32'h204, 0);
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 1, 32'h208 + 32'(4 * k), 1);
      chk("pp_count", 32'(bus.count_o), 32'd2);
      chk("pp_head",  bus.id_pc_o, 32'h200 + 32'(4 * k));
    end

    // Flush at occupancy 3 with a same-cycle push and pop.
    drive(0, 1, 0, 32'h0, 0);
    drive(0, 0, 1, 32'h0, 0);
    drive(0, 0, 1, 32'h4, 0);
    drive(0, 0, 1, 32'h8, 0);
    drive(0, 1, 1, 32'h40, 1);
    chk("flush_cyc_count", 32'(bus.count_o), 32'd3);
    chk("flush_cyc_head",  bus.id_pc_o, 32'h0);
    drive(0, 0, 1, 32'h80, 0);
    chk("post_flush_count", 32'(bus.count_o), 32'd0);
    chk("post_flush_valid", 32'(bus.id_valid_o), 32'd0);
    chk("post_flush_ready", 32'(bus.if_ready_o), 32'd1);
    drive(0, 0, 0, 32'h0, 0);
    chk("flush_next_head", bus.id_pc_o, 32'h80);
    chk("flush_next_cnt",  32'(bus.count_o), 32'd1);

    // Pops on an empty queue are ignored.
    drive(0, 0, 0, 32'h0, 1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 32'h0, 1);
      chk("empty_count", 32'(bus.count_o), 32'd0);
      chk("empty_pc",    bus.id_pc_o, 32'h0);
      chk("empty_instr", bus.id_instr_o, 32'h13);
    end
    drive(0, 0, 1, 32'h300, 0);
    drive(0, 0, 0, 32'h0, 0);
    chk("after_empty_head", bus.id_pc_o, 32'h300);

    // Reset mid-operation discards queued entries.
    drive(0, 0, 1, 32'h304, 0);
    drive(1, 0, 1, 32'h308, 1);
    chk("midrst_ready", 32'(bus.if_ready_o), 32'd0);
    chk("midrst_count", 32'(bus.count_o), 32'd2);
    drive(0, 0, 0, 32'h0, 0);
    chk("postrst_count", 32'(bus.count_o), 32'd0);
    chk("postrst_valid", 32'(bus.id_valid_o), 32'd0);
    chk("pc40_never_out", 32'(seen_40), 32'd0);

    // Random traffic with a slowly varying ID stall bias.
    bias = 50;
    for (int k = 0; k < 3000; k++) begin
      if ((k % 200) == 0) bias = int'($urandom_range(10, 90));
      drive(logic'($urandom_range(0, 99) == 0),
            logic'($urandom_range(0, 19) == 0),
            logic'($urandom_range(0, 9) < 7),
            32'h1000_0000 | ($urandom & 32'h0FFF_FFFC),
            logic'(int'($urandom_range(0, 99)) < bias));
    end
    drive(0, 0, 0, 32'h0, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the IF stage and the ID stage. Captures each fetched PC/instruction pair from IF into a small circular FIFO and presents them in order to ID with a valid/ready handshake. Back-pressure goes to IF through `if_ready_o`, which IF uses as its PC write enable. A flush input discards everything in flight on branch/jump redirect.

## Interface
- `DATA_WIDTH`, 32: PC and instruction width.
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `NOP_INSTR`, 32'h0000_0013: value driven on `id_instr_o` when empty (`addi x0,x0,0`).

Reset is synchronous and active-high. There is one clock.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  discard all entries and any same-cycle push/pop.
- `if_valid_i`  in  1  IF presents a valid PC/instruction.
- `if_pc_i`  in  DATA_WIDTH  fetched PC.
- `if_instr_i`  in  DATA_WIDTH  fetched instruction.
- `if_ready_o`  out  1  queue accepts a push this cycle; drives IF `pc_we`.
- `id_valid_o`  out  1  head entry valid.
- `id_pc_o`  out  DATA_WIDTH  head PC.
- `id_instr_o`  out  DATA_WIDTH  head instruction.
- `id_ready_i`  in  1  ID consumes the head this cycle.
- `count_o`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- **Storage:** `DEPTH`-entry PC and instruction arrays; `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` runs 0..DEPTH.
- **Ready/valid:**
  - `if_ready_o = !rst && (count != DEPTH)`.
  - `id_valid_o = (count != 0)`.
- **Push** = `if_valid_i && if_ready_o && !flush_i`. It writes the entry at `wr_ptr` and advances `wr_ptr` by 1.
- **Pop** = `id_valid_o && id_ready_i && !flush_i`. It advances `rd_ptr` by 1.
- **Count update:**
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged, both pointers advance.
- **Head outputs:** `id_pc_o` and `id_instr_o` come combinationally from entry `rd_ptr` when `count != 0`. When empty they are `0` and `NOP_INSTR`.
- **No bypass:** an instruction pushed in cycle N is never visible to ID in cycle N.
- **Full:** `if_ready_o = 0`, so no push happens. A pop in that cycle frees a slot, but `if_ready_o` only rises in the next cycle (no same-cycle full-bypass).
- **Empty:** `id_ready_i` is ignored and pointers do not move.
- **Flush:** on the next edge, `count`, `wr_ptr` and `rd_ptr` go to 0. Any push or pop in the flush cycle is dropped. Array contents are not cleared.
- **Flush and rst together:** identical result, reset state.
- **Reset mid-operation:** all queued entries are lost and the handshake restarts from empty.
- **Illegal input:** `if_valid_i` with X on data is a don't-care only if not pushed. The assertion `count <= DEPTH` is always checked.

## Timing
- **Reset values (edge after `rst` high):**
  - `count_o` = 0, pointers = 0.
  - `id_valid_o` = 0, `id_pc_o` = 0, `id_instr_o` = `NOP_INSTR`.
  - `if_ready_o` = 0 while `rst` is high, then 1 on the first cycle after.
- **Latency:** push at edge N makes the entry visible at the head from cycle N+1, provided it is the oldest entry.
- **Throughput:** one push and one pop per cycle sustained; the queue stays at constant occupancy with no bubbles.
- **Timing paths:**
  - `if_ready_o` and `id_valid_o` depend only on registered state (plus `rst` for `if_ready_o`). No combinational path from `id_ready_i` to `if_ready_o`.
  - The head data path is a DEPTH:1 mux on `rd_ptr`.
- **Flush cycle:** during the flush cycle itself the outputs still reflect the pre-flush state. From the next cycle `id_valid_o` = 0 and `if_ready_o` = 1.

## Test plan
- **Reset:** hold `rst` 2 cycles with `if_valid_i`=1.
  - Required: `if_ready_o`=0, `id_valid_o`=0, `id_instr_o`=32'h13, `count_o`=0.
  - After release: `if_ready_o`=1.
- **Fill to full:** `id_ready_i`=0, push PCs 0x0, 0x4, 0x8, 0xC.
  - `count_o` steps 1→4.
  - `if_ready_o`=0 in the cycle after the 4th push.
  - A 5th `if_valid_i` with PC 0x10 is not accepted.
  - The head stays PC 0x0.
- **Drain order/wrap:** from full, set `id_ready_i`=1 and keep pushing 0x10, 0x14, … once ready.
  - ID sees 0x0, 0x4, 0x8, 0xC, 0x10, 0x14 in order with no gaps.
  - Pointers wrap past DEPTH−1.
- **Simultaneous push/pop:** at `count`=2, assert both for 10 cycles.
  - `count_o` stays 2.
  - Output PCs are strictly +4 sequential.
- **Flush:** at `count`=3, assert `flush_i` together with `if_valid_i` (PC 0x40) and `id_ready_i`.
  - Next cycle: `count_o`=0, `id_valid_o`=0.
  - PC 0x40 is never output.
  - The next push of 0x80 appears at the head one cycle later.
- **Empty pop:** with `count`=0, assert `id_ready_i` for 3 cycles.
  - Pointers stay unchanged and `count_o`=0.
  - `id_pc_o`=0.
